// File: rtl/add_accumulator.sv
// add_accumulator: accumulates a group of 16-bit unsigned operands delimited by in_last.
// Each operand is added with a single-cycle parallel-prefix adder. The group result
// (sum, sticky carry, saturating count) is then held until downstream takes it.
module add_accumulator #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [16:1]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [16:1]      out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CountMax = '1;
  localparam logic [CNT_W-1:0] CountOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        in_fire;
  logic        out_fire;
  logic [15:0] operand;
  logic [15:0] add_sum;
  logic        add_carry;

  // Kogge-Stone recursive-doubling adder, carry-in 0. Returns {carry_out, sum}.
  function automatic logic [16:0] prefix_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] g_n;
    logic [15:0] p_n;
    logic [15:0] p0;
    logic [15:0] c;
    g  = a & b;
    p  = a ^ b;
    p0 = p;
    for (int lvl = 0; lvl < 4; lvl++) begin
      for (int i = 0; i < 16; i++) begin
        if (i >= (1 << lvl)) begin
          g_n[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
          p_n[i] = p[i] & p[i - (1 << lvl)];
        end else begin
          g_n[i] = g[i];
          p_n[i] = p[i];
        end
      end
      g = g_n;
      p = p_n;
    end
    // After the last level g[i] is the group generate over bits [i:0], i.e. carry into i+1.
    c = {g[14:0], 1'b0};
    return {g[15], p0 ^ c};
  endfunction

  // Bit 1 of in_data is the LSB, so a straight width-matched copy maps it to operand[0].
  assign operand = in_data;

  // Single-cycle add of the running accumulator and the incoming operand
  always_comb begin
    logic [16:0] res;
    res       = prefix_add(acc_q, operand);
    add_sum   = res[15:0];
    add_carry = res[16];
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register; synchronous reset wins over any concurrent transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StAcc: begin
        if (in_fire) begin
          state_d = in_last ? StDone : StAcc;
        end
      end
      StDone: begin
        if (out_fire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs are a pure function of state; in_ready never looks at out_ready
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle, StAcc: in_ready  = 1'b1;
      StDone:        out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath next-state: load on the first operand, accumulate after, clear on result take
  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          acc_d   = operand;
          ovf_d   = 1'b0;
          count_d = CountOne;
        end
      end
      StAcc: begin
        if (in_fire) begin
          acc_d   = add_sum;
          ovf_d   = ovf_q | add_carry;
          count_d = (count_q == CountMax) ? count_q : count_q + CountOne;
        end
      end
      StDone: begin
        if (out_fire) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
        end
      end
      default: begin
        acc_d   = '0;
        ovf_d   = 1'b0;
        count_d = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  // Result outputs come straight from registers so nothing combinational reaches them
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_add_accumulator.sv
// Directed self-checking bench for add_accumulator. Inputs change and outputs are
// sampled on the falling edge, half a period away from the active rising edge.
module tb_add_accumulator;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [16:1]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [16:1]      out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  int errors = 0;
  int checks = 0;

  add_accumulator #(
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand for exactly one rising edge, returning at the next falling edge.
  task automatic send(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_sum !== 16'h0) begin errors++; $display("FAIL reset_sum got=%h exp=0000", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", out_ovf); end
    checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", out_count); end
  endtask

  task automatic test_three_ops();
    out_ready = 1'b1;
    send(16'h0001, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL three_mid_valid got=%b exp=0", out_valid); end
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL three_valid got=%b exp=1", out_valid); end
    checks++; if (out_sum !== 16'h0006) begin errors++; $display("FAIL three_sum got=%h exp=0006", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL three_ovf got=%b exp=0", out_ovf); end
    checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL three_count got=%0d exp=3", out_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL three_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL three_idle_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL three_idle_ready got=%b exp=1", in_ready); end
    checks++; if (out_sum !== 16'h0) begin errors++; $display("FAIL three_cleared_sum got=%h exp=0000", out_sum); end
  endtask

  // Two-operand groups exercising short and long carry chains through the prefix tree.
  task automatic test_pairs();
    logic [15:0] va [6] = '{16'hFFFF, 16'h00FF, 16'h0F0F, 16'h1234, 16'h7FFF, 16'hFFFF};
    logic [15:0] vb [6] = '{16'h0002, 16'h0001, 16'hF0F1, 16'h5678, 16'h0001, 16'hFFFF};
    logic [15:0] es [6] = '{16'h0001, 16'h0100, 16'h0000, 16'h68AC, 16'h8000, 16'hFFFE};
    logic        eo [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(va[i], 1'b0);
      send(vb[i], 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pair%0d_valid got=%b exp=1", i, out_valid); end
      checks++; if (out_sum !== es[i]) begin errors++; $display("FAIL pair%0d_sum got=%h exp=%h", i, out_sum, es[i]); end
      checks++; if (out_ovf !== eo[i]) begin errors++; $display("FAIL pair%0d_ovf got=%b exp=%b", i, out_ovf, eo[i]); end
      checks++; if (out_count !== 8'd2) begin errors++; $display("FAIL pair%0d_count got=%0d exp=2", i, out_count); end
      @(negedge clk);
    end
  endtask

  // Carry from an early wrap must survive later non-carrying additions.
  task automatic test_sticky_ovf();
    out_ready = 1'b1;
    send(16'hFFFF, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0001, 1'b1);
    checks++; if (out_sum !== 16'h0001) begin errors++; $display("FAIL sticky_sum got=%h exp=0001", out_sum); end
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL sticky_ovf got=%b exp=1", out_ovf); end
    checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL sticky_count got=%0d exp=3", out_count); end
    @(negedge clk);
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    send(16'hA5A5, 1'b1);
    // Offer a competing operand during the hold; it must not be taken.
    in_valid = 1'b1;
    in_data  = 16'h1111;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_valid got=%b exp=1", i, out_valid); end
      checks++; if (out_sum !== 16'hA5A5) begin errors++; $display("FAIL hold%0d_sum got=%h exp=a5a5", i, out_sum); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_in_ready got=%b exp=0", i, in_ready); end
      checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL hold%0d_count got=%0d exp=1", i, out_count); end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    in_last   = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid got=%b exp=1", out_valid); end
    checks++; if (out_sum !== 16'h1234) begin errors++; $display("FAIL b2b_first_sum got=%h exp=1234", out_sum); end
    checks++; if (out_count !== 8'd1 || out_ovf !== 1'b0) begin
      errors++; $display("FAIL b2b_first_cnt_ovf got=%0d/%b exp=1/0", out_count, out_ovf);
    end
    in_data = 16'h4321;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got=%b exp=1", out_valid); end
    checks++; if (out_sum !== 16'h4321) begin errors++; $display("FAIL b2b_second_sum got=%h exp=4321", out_sum); end
    checks++; if (out_count !== 8'd1 || out_ovf !== 1'b0) begin
      errors++; $display("FAIL b2b_second_cnt_ovf got=%0d/%b exp=1/0", out_count, out_ovf);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0001;
      in_last  = (i == 299);
      @(negedge clk);
      if (i == 254) begin
        checks++; if (out_count !== 8'd255) begin errors++; $display("FAIL sat_reach got=%0d exp=255", out_count); end
      end
      if (i == 255) begin
        checks++; if (out_count !== 8'd255) begin errors++; $display("FAIL sat_hold got=%0d exp=255", out_count); end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got=%b exp=1", out_valid); end
    checks++; if (out_sum !== 16'h012C) begin errors++; $display("FAIL sat_sum got=%h exp=012c", out_sum); end
    checks++; if (out_count !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d exp=255", out_count); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf got=%b exp=0", out_ovf); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(16'h0007, 1'b0);
    send(16'h0009, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    checks++; if (out_sum !== 16'h0 || out_count !== 8'd0) begin
      errors++; $display("FAIL rstmid_state got=%h/%0d exp=0000/0", out_sum, out_count);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", in_ready); end
    send(16'h0005, 1'b1);
    checks++; if (out_sum !== 16'h0005) begin errors++; $display("FAIL rstmid_new_sum got=%h exp=0005", out_sum); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL rstmid_new_count got=%0d exp=1", out_count); end
    @(negedge clk);
    // Reset while a result is pending, with a competing operand offered on the same edge.
    out_ready = 1'b0;
    send(16'h0042, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstdone_pre_valid got=%b exp=1", out_valid); end
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h9999;
    in_last  = 1'b1;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstdone_valid got=%b exp=0", out_valid); end
    checks++; if (out_sum !== 16'h0 || out_count !== 8'd0) begin
      errors++; $display("FAIL rstdone_state got=%h/%0d exp=0000/0", out_sum, out_count);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstdone_stale got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_three_ops();
    test_pairs();
    test_sticky_ovf();
    test_hold();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
